// File: rtl/timer_pkg.sv
// Shared definitions for the programmable countdown timer.
// State encodings and the sub-second counter width helper.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

  function automatic int SUBW(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Sub-second counter: divides the clock into whole and half seconds.
// Ticks are raw counter decodes; the owner gates them with its state.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int CLKS_PER_SEC = 10,
  parameter int SW = SUBW(CLKS_PER_SEC)
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_load,
  input  logic i_en,
  output logic o_sec_tick,
  output logic o_half_tick
);

  localparam logic [SW-1:0] LP_TOP  = SW'(CLKS_PER_SEC - 1);
  localparam logic [SW-1:0] LP_HALF = SW'(CLKS_PER_SEC / 2);
  localparam logic [SW-1:0] LP_ONE  = SW'(1);

  logic [SW-1:0] r_sub_cnt;

  // Clear wins over load; enabled counting wraps 0 back to the top.
  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_sub_cnt <= '0;
    end else if (i_load) begin
      r_sub_cnt <= LP_TOP;
    end else if (i_en) begin
      r_sub_cnt <= (r_sub_cnt == '0) ? LP_TOP : r_sub_cnt - LP_ONE;
    end
  end

  assign o_sec_tick  = (r_sub_cnt == '0);
  assign o_half_tick = (r_sub_cnt == '0) || (r_sub_cnt == LP_HALF);

endmodule

// File: rtl/prog_timer.sv
// Programmable seconds countdown with retrigger, abort and tick outputs.
// Define TIMER_PAUSE_EN to add the i_pause_timer port and PAUSED state.
module prog_timer
  import timer_pkg::*;
#(
  parameter int CLKS_PER_SEC = 10,
  parameter int VALUE_W = 4
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [VALUE_W-1:0] i_value,
  input  logic               i_start_timer,
  input  logic               i_abort_timer,
`ifdef TIMER_PAUSE_EN
  input  logic               i_pause_timer,
`endif
  output logic               o_expired,
  output logic               o_one_hz_enable,
  output logic               o_half_hz_enable,
  output logic [VALUE_W-1:0] o_remaining,
  output logic               o_busy
);

  localparam logic [VALUE_W-1:0] LP_ONE = VALUE_W'(1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [VALUE_W-1:0] r_sec_left;
  logic [VALUE_W-1:0] w_sec_nxt;
  logic               w_sub_clr;
  logic               w_sub_load;
  logic               w_sub_en;
  logic               w_sub_zero;
  logic               w_sub_half;
  logic               w_step;

  timer_prescaler #(
    .CLKS_PER_SEC(CLKS_PER_SEC)
  ) u_prescaler (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_clear    (w_sub_clr),
    .i_load     (w_sub_load),
    .i_en       (w_sub_en),
    .o_sec_tick (w_sub_zero),
    .o_half_tick(w_sub_half)
  );

  // State and seconds registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_sec_left <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_sec_left <= w_sec_nxt;
    end
  end

  // Next state: abort, then start, then pause, then counting.
  always_comb begin
    w_state_nxt = r_state;
    w_sec_nxt   = r_sec_left;
    w_sub_clr   = 1'b0;
    w_sub_load  = 1'b0;
    w_sub_en    = 1'b0;
    w_step      = 1'b0;
    if (i_abort_timer) begin
      w_state_nxt = ST_IDLE;
      w_sec_nxt   = '0;
      w_sub_clr   = 1'b1;
    end else if (i_start_timer) begin
      if (i_value != '0) begin
        w_state_nxt = ST_RUN;
        w_sec_nxt   = i_value;
        w_sub_load  = 1'b1;
      end else begin
        w_state_nxt = ST_IDLE;
        w_sec_nxt   = '0;
        w_sub_clr   = 1'b1;
      end
    end else begin
      case (r_state)
        ST_RUN: begin
`ifdef TIMER_PAUSE_EN
          if (i_pause_timer) begin
            w_state_nxt = ST_PAUSED;
          end else begin
            w_step = 1'b1;
          end
`else
          w_step = 1'b1;
`endif
        end
`ifdef TIMER_PAUSE_EN
        ST_PAUSED: begin
          if (!i_pause_timer) begin
            w_state_nxt = ST_RUN;
            w_step      = 1'b1;
          end
        end
`endif
        default: w_state_nxt = r_state;
      endcase
      if (w_step) begin
        if (w_sub_zero && (r_sec_left <= LP_ONE)) begin
          w_state_nxt = ST_IDLE;
          w_sec_nxt   = '0;
        end else begin
          w_sub_en = 1'b1;
          if (w_sub_zero) begin
            w_sec_nxt = r_sec_left - LP_ONE;
          end
        end
      end
    end
  end

  assign o_one_hz_enable  = (r_state == ST_RUN) && w_sub_zero;
  assign o_half_hz_enable = (r_state == ST_RUN) && w_sub_half;
  assign o_expired        = (r_state == ST_IDLE) && (r_sec_left == '0);
  assign o_busy           = (r_state != ST_IDLE);
  assign o_remaining      = r_sec_left;

endmodule

// File: tb/tb_prog_timer.sv
// Directed bench for prog_timer at CLKS_PER_SEC=10, VALUE_W=4.
// Cycle c is the period ending at edge c; inputs set in it are sampled there.
module tb_prog_timer;

  localparam int C    = 10;
  localparam int W    = 4;
  localparam int MAXC = 480;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] value;
  logic         start;
  logic         abort;
  logic         pause;
  logic         expired;
  logic         one_hz;
  logic         half_hz;
  logic [W-1:0] remaining;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         cyc;
    bit         drv;
    bit         start;
    bit         abort;
    bit         pause;
    logic [3:0] value;
    bit         chk;
    bit         one;
    bit         half;
    bit         exp;
    bit         busy;
    logic [3:0] rem;
  } vec_t;

  typedef struct {
    int lo;
    int hi;
    bit hit;
    int first;
  } win_t;

  vec_t tv[$];
  win_t qw[$];

  always #5 clk = ~clk;

  prog_timer #(
    .CLKS_PER_SEC(C),
    .VALUE_W(W)
  ) dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .i_value         (value),
    .i_start_timer   (start),
    .i_abort_timer   (abort),
`ifdef TIMER_PAUSE_EN
    .i_pause_timer   (pause),
`endif
    .o_expired       (expired),
    .o_one_hz_enable (one_hz),
    .o_half_hz_enable(half_hz),
    .o_remaining     (remaining),
    .o_busy          (busy)
  );

  task automatic cmp(input string nm, input int c,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, c, act, exp);
    end
  endtask

  task automatic d(input int c, input bit s, input bit a,
                   input bit p, input logic [3:0] v);
    vec_t e;
    e = '{default: '0};
    e.cyc = c; e.drv = 1'b1;
    e.start = s; e.abort = a; e.pause = p; e.value = v;
    tv.push_back(e);
  endtask

  task automatic k(input int c, input bit o, input bit h,
                   input bit x, input bit b, input logic [3:0] r);
    vec_t e;
    e = '{default: '0};
    e.cyc = c; e.chk = 1'b1;
    e.one = o; e.half = h; e.exp = x; e.busy = b; e.rem = r;
    tv.push_back(e);
  endtask

  task automatic quiet(input int lo, input int hi);
    win_t w;
    w.lo = lo; w.hi = hi; w.hit = 1'b0; w.first = -1;
    qw.push_back(w);
  endtask

  initial begin
    int n;
    bit seen;

    // value=3 plain countdown
    d(10, 1, 0, 0, 4'd3);
    k(10, 0, 0, 1, 0, 4'd0);
    k(11, 0, 0, 0, 1, 4'd3);
    k(15, 0, 1, 0, 1, 4'd3);
    k(16, 0, 0, 0, 1, 4'd3);
    k(19, 0, 0, 0, 1, 4'd3);
    k(20, 1, 1, 0, 1, 4'd3);
    k(21, 0, 0, 0, 1, 4'd2);
    k(25, 0, 1, 0, 1, 4'd2);
    k(30, 1, 1, 0, 1, 4'd2);
    k(31, 0, 0, 0, 1, 4'd1);
    k(35, 0, 1, 0, 1, 4'd1);
    k(40, 1, 1, 0, 1, 4'd1);
    k(41, 0, 0, 1, 0, 4'd0);
    quiet(41, 90);
    // value=5 with abort at relative cycle 23
    d(100, 1, 0, 0, 4'd5);
    d(123, 0, 1, 0, 4'd0);
    k(120, 1, 1, 0, 1, 4'd4);
    k(123, 0, 0, 0, 1, 4'd3);
    k(124, 0, 0, 1, 0, 4'd0);
    quiet(124, 180);
    // value=4 retriggered with value=2 at relative cycle 15
    d(200, 1, 0, 0, 4'd4);
    d(215, 1, 0, 0, 4'd2);
    k(210, 1, 1, 0, 1, 4'd4);
    k(215, 0, 1, 0, 1, 4'd3);
    k(216, 0, 0, 0, 1, 4'd2);
    quiet(216, 219);
    k(220, 0, 1, 0, 1, 4'd2);
    k(225, 1, 1, 0, 1, 4'd2);
    k(226, 0, 0, 0, 1, 4'd1);
    k(230, 0, 1, 0, 1, 4'd1);
    k(235, 1, 1, 0, 1, 4'd1);
    k(236, 0, 0, 1, 0, 4'd0);
    quiet(236, 290);
    // zero load, start with abort, zero load while running
    d(300, 1, 0, 0, 4'd0);
    k(301, 0, 0, 1, 0, 4'd0);
    k(305, 0, 0, 1, 0, 4'd0);
    quiet(300, 319);
    d(320, 1, 1, 0, 4'd5);
    k(321, 0, 0, 1, 0, 4'd0);
    quiet(321, 329);
    d(330, 1, 0, 0, 4'd3);
    k(331, 0, 0, 0, 1, 4'd3);
    d(335, 1, 0, 0, 4'd0);
    k(335, 0, 1, 0, 1, 4'd3);
    k(336, 0, 0, 1, 0, 4'd0);
    quiet(336, 360);
`ifdef TIMER_PAUSE_EN
    // value=2 with pause held over cycles 7..16
    d(400, 1, 0, 0, 4'd2);
    for (int c = 407; c <= 416; c++) d(c, 0, 0, 1, 4'd0);
    k(407, 0, 0, 0, 1, 4'd2);
    k(410, 0, 0, 0, 1, 4'd2);
    k(417, 0, 0, 0, 1, 4'd2);
    quiet(406, 419);
    k(420, 1, 1, 0, 1, 4'd2);
    k(421, 0, 0, 0, 1, 4'd1);
    k(425, 0, 1, 0, 1, 4'd1);
    k(430, 1, 1, 0, 1, 4'd1);
    k(431, 0, 0, 1, 0, 4'd0);
`endif

    rst = 1'b1; value = '0; start = 1'b0; abort = 1'b0; pause = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp("rst_expired", -1, expired, 1);
    cmp("rst_busy", -1, busy, 0);
    cmp("rst_remaining", -1, remaining, 0);
    cmp("rst_one_hz", -1, one_hz, 0);
    cmp("rst_half_hz", -1, half_hz, 0);
    rst = 1'b0;

    for (int c = 0; c <= MAXC; c++) begin
      @(negedge clk);
      foreach (tv[i]) begin
        if (tv[i].chk && tv[i].cyc == c) begin
          cmp("one_hz", c, one_hz, tv[i].one);
          cmp("half_hz", c, half_hz, tv[i].half);
          cmp("expired", c, expired, tv[i].exp);
          cmp("busy", c, busy, tv[i].busy);
          cmp("remaining", c, remaining, tv[i].rem);
        end
      end
      foreach (qw[i]) begin
        if (c >= qw[i].lo && c <= qw[i].hi && (one_hz || half_hz)
            && !qw[i].hit) begin
          qw[i].hit = 1'b1;
          qw[i].first = c;
        end
        if (c == qw[i].hi) cmp("quiet_window_tick", qw[i].first, qw[i].hit, 0);
      end
      start = 1'b0; abort = 1'b0; pause = 1'b0; value = '0;
      foreach (tv[i]) begin
        if (tv[i].drv && tv[i].cyc == c) begin
          start = tv[i].start;
          abort = tv[i].abort;
          pause = tv[i].pause;
          value = tv[i].value;
        end
      end
    end

    // start held high keeps reloading: no ticks until released
    start = 1'b1; value = 4'd1;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (one_hz || half_hz) seen = 1'b1;
    end
    cmp("hold_start_ticks", 0, seen, 0);
    cmp("hold_start_busy", 0, busy, 1);
    cmp("hold_start_rem", 0, remaining, 1);
    start = 1'b0; value = '0;
    n = 0;
    seen = 1'b0;
    while (n < 20 && !seen) begin
      @(negedge clk);
      n++;
      if (one_hz) seen = 1'b1;
    end
    cmp("release_tick_seen", n, seen, 1);
    cmp("release_latency", n, n, 9);
    @(negedge clk);
    cmp("release_expired", 0, expired, 1);
    cmp("release_busy", 0, busy, 0);

    // reset overrides a running count
    start = 1'b1; value = 4'd9;
    @(negedge clk);
    start = 1'b0; value = '0;
    repeat (3) @(negedge clk);
    cmp("midrun_busy_pre", 0, busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cmp("midrun_rst_busy", 0, busy, 0);
    cmp("midrun_rst_rem", 0, remaining, 0);
    cmp("midrun_rst_expired", 0, expired, 1);
    cmp("midrun_rst_one_hz", 0, one_hz, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
